hsv_colour_bbox: RTL
====================

Name: hsv_colour_bbox

Overview:
- Sits directly downstream of the RGB-to-HSV converter in the vision pipeline.
- Consumes the per-pixel HSV stream (hsv_h 10-bit degrees 0..359, hsv_s and hsv_v 8-bit).
- Classifies each pixel against a programmable colour window and emits a registered per-pixel mask.
- Accumulates the bounding box and pixel count of matching pixels over one frame, then reports them once per frame for the rover's target-finding logic.

Parameters:
- IMG_W, 640, active pixels per line; x wraps at IMG_W-1.
- IMG_H, 480, active lines per frame; y saturates at IMG_H-1.
- MIN_COUNT, 16, minimum matching-pixel count for bbox_found=1.

Ports:
- clk  in  1  single pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  HSV pixel beat valid.
- in_sop  in  1  first pixel of frame; qualified by in_valid.
- in_eop  in  1  last pixel of frame; qualified by in_valid.
- hsv_h  in  10  hue, 0..359.
- hsv_s  in  8  saturation.
- hsv_v  in  8  value.
- cfg_h_lo  in  10  hue window low bound, inclusive.
- cfg_h_hi  in  10  hue window high bound, inclusive.
- cfg_s_min  in  8  minimum saturation, inclusive.
- cfg_v_min  in  8  minimum value, inclusive.
- mask_valid  out  1  registered copy of in_valid.
- mask  out  1  pixel matched the window.
- bbox_valid  out  1  one-cycle pulse carrying the frame result.
- bbox_found  out  1  count >= MIN_COUNT.
- bbox_x_min  out  10  bounding box left edge.
- bbox_x_max  out  10  bounding box right edge.
- bbox_y_min  out  9  bounding box top edge.
- bbox_y_max  out  9  bounding box bottom edge.
- bbox_count  out  19  matching pixels in frame, saturating at 2^19-1.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; x=0, y=0.
  - Accumulators: min regs at max value, max regs 0, count 0.
- Config capture: cfg_* are latched into shadow registers on every accepted in_sop beat. Changes mid-frame have no effect until the next frame.
- Match rule:
  - s >= s_min and v >= v_min, and a hue test.
  - If h_lo <= h_hi: h_lo <= h <= h_hi.
  - If h_lo > h_hi (wrap, e.g. red 340..20): h >= h_lo or h <= h_hi.
  - The in_sop beat itself uses the incoming cfg_* values (bypass of the shadow registers).
- Mask latency: mask_valid and mask are registered one cycle after the input beat. mask=0 whenever mask_valid=0.
- Coordinates:
  - The in_sop beat is pixel (0,0).
  - Each later valid beat increments x; at x==IMG_W-1 it wraps to 0 and y increments.
  - y holds at IMG_H-1 (no wrap).
  - in_valid=0 stalls everything, with no state change.
- State machine:
  - IDLE: ignore beats until in_valid & in_sop, then go to ACTIVE. The accumulators are cleared and then updated with pixel (0,0).
  - ACTIVE: update the accumulators on each matching valid beat. On in_valid & in_eop, include that pixel and go to REPORT.
  - REPORT: lasts one cycle. Drives bbox_valid=1 together with the outputs, then returns to IDLE. Input beats arriving in REPORT are treated as in IDLE: an sop beat starts a new frame immediately.
- Result timing: if the eop beat is sampled at edge N, bbox_valid is high during the cycle after edge N+1. bbox_* hold their values until the next report.
- Boundary conditions:
  - sop and eop on the same beat: single-pixel frame; go straight to REPORT.
  - in_sop while ACTIVE: abandon the current frame with no report; restart the accumulators at (0,0).
  - Zero matches: bbox_found=0, bbox_count=0, and the bbox coordinate outputs report 0.
  - Reset mid-frame: the frame is discarded and the block returns to IDLE.
  - Count saturates; it does not wrap.

Decomposition:
- Package hsv_vision_pkg:
  - Widths: H_W=10, SV_W=8, X_W=10, Y_W=9, CNT_W=19.
  - Constant HUE_MAX=359.
  - A typedef struct bbox_t {x_min, x_max, y_min, y_max, count, found}, shared with downstream consumers.
- One sub-module, hsv_window_match: the combinational match function, including hue wrap. It is reused later for multi-colour instances.

Test Plan:
- Window 100..140, s_min=50, v_min=50; single pixel h=120,s=200,v=200 at (5,3) -> mask=1 one cycle later; bbox 5..5/3..3, count=1, found=0 (MIN_COUNT=16).
- Wrap window 340..20; pixels h=350, h=10, h=30 at x=0,1,2 on line 0 -> masks 1,1,0; x_min=0, x_max=1.
- 4x4 block of matching pixels at x=100..103, y=200..203 in a full 640x480 frame -> count=16, found=1, bbox 100..103/200..203, bbox_valid exactly one cycle.
- s=49 with s_min=50 (and v=v_min-1 in a separate case) -> mask=0; s=50 -> mask=1 (inclusive bounds).
- sop at (0,0), 10 matching beats, a second sop, 3 matching beats then eop -> only one bbox_valid, count=3.
- in_valid gaps of 0..5 random cycles between beats -> results identical to the gap-free run; rst asserted mid-frame -> all outputs 0, no report.

Source files
------------

// File: rtl/hsv_vision_pkg.sv
// Shared widths, FSM state and the frame-result record for the HSV vision blocks.
package hsv_vision_pkg;

  localparam int H_W   = 10;
  localparam int SV_W  = 8;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CNT_W = 19;

  localparam logic [H_W-1:0] HUE_MAX = 10'd359;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REPORT = 2'd2
  } bbox_state_t;

  typedef struct packed {
    logic [X_W-1:0]   x_min;
    logic [X_W-1:0]   x_max;
    logic [Y_W-1:0]   y_min;
    logic [Y_W-1:0]   y_max;
    logic [CNT_W-1:0] count;
    logic             found;
  } bbox_t;

  // A window with lo > hi wraps through 0 (e.g. red at 340..20).
  function automatic logic hue_in_window(input logic [H_W-1:0] h,
                                         input logic [H_W-1:0] lo,
                                         input logic [H_W-1:0] hi);
    logic in_s;
    if (lo <= hi) begin
      in_s = (h >= lo) && (h <= hi);
    end else begin
      in_s = (h >= lo) || (h <= hi);
    end
    return in_s;
  endfunction

endpackage

// File: rtl/hsv_colour_bbox_if.sv
// Per-pixel HSV beat stream from the RGB-to-HSV converter.
interface hsv_colour_bbox_if;
  import hsv_vision_pkg::*;

  logic            in_valid;
  logic            in_sop;
  logic            in_eop;
  logic [H_W-1:0]  hsv_h;
  logic [SV_W-1:0] hsv_s;
  logic [SV_W-1:0] hsv_v;

  modport master (output in_valid, in_sop, in_eop, hsv_h, hsv_s, hsv_v);
  modport slave  (input  in_valid, in_sop, in_eop, hsv_h, hsv_s, hsv_v);
endinterface

// File: rtl/hsv_window_match.sv
// Combinational colour-window classifier; reusable for several colour instances.
module hsv_window_match
  import hsv_vision_pkg::*;
(
  input  logic [H_W-1:0]  h,
  input  logic [H_W-1:0]  h_lo,
  input  logic [H_W-1:0]  h_hi,
  input  logic [SV_W-1:0] s,
  input  logic [SV_W-1:0] v,
  input  logic [SV_W-1:0] s_min,
  input  logic [SV_W-1:0] v_min,
  output logic            match
);

  // Saturation/value floors plus the (possibly wrapping) hue window.
  always_comb begin
    match = (s >= s_min) && (v >= v_min) && hue_in_window(h, h_lo, h_hi);
  end

endmodule

// File: rtl/hsv_colour_bbox.sv
// Per-pixel colour mask plus once-per-frame bounding box and count of matching pixels.
module hsv_colour_bbox
  import hsv_vision_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int MIN_COUNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  hsv_colour_bbox_if.slave  pix,
  input  logic [H_W-1:0]    cfg_h_lo,
  input  logic [H_W-1:0]    cfg_h_hi,
  input  logic [SV_W-1:0]   cfg_s_min,
  input  logic [SV_W-1:0]   cfg_v_min,
  output logic              mask_valid,
  output logic              mask,
  output logic              bbox_valid,
  output logic              bbox_found,
  output logic [X_W-1:0]    bbox_x_min,
  output logic [X_W-1:0]    bbox_x_max,
  output logic [Y_W-1:0]    bbox_y_min,
  output logic [Y_W-1:0]    bbox_y_max,
  output logic [CNT_W-1:0]  bbox_count
);

  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  bbox_state_t      state_r, state_nxt_s;
  logic             sop_beat_s, frame_start_s, accum_s, report_s, match_s;
  logic [H_W-1:0]   sh_h_lo_r, sh_h_hi_r, eff_h_lo_s, eff_h_hi_s;
  logic [SV_W-1:0]  sh_s_min_r, sh_v_min_r, eff_s_min_s, eff_v_min_s;
  logic [X_W-1:0]   x_r, px_s, acc_x_min_r, acc_x_max_r;
  logic [Y_W-1:0]   y_r, py_s, acc_y_min_r, acc_y_max_r;
  logic [CNT_W-1:0] acc_count_r;
  bbox_t            bbox_r;

  assign sop_beat_s = pix.in_valid & pix.in_sop;

  // The sop beat sees the live config; every later beat uses the frame's shadow copy.
  always_comb begin
    if (sop_beat_s) begin
      eff_h_lo_s  = cfg_h_lo;
      eff_h_hi_s  = cfg_h_hi;
      eff_s_min_s = cfg_s_min;
      eff_v_min_s = cfg_v_min;
    end else begin
      eff_h_lo_s  = sh_h_lo_r;
      eff_h_hi_s  = sh_h_hi_r;
      eff_s_min_s = sh_s_min_r;
      eff_v_min_s = sh_v_min_r;
    end
  end

  hsv_window_match u_match (
    .h     (pix.hsv_h),
    .h_lo  (eff_h_lo_s),
    .h_hi  (eff_h_hi_s),
    .s     (pix.hsv_s),
    .v     (pix.hsv_v),
    .s_min (eff_s_min_s),
    .v_min (eff_v_min_s),
    .match (match_s)
  );

  // Coordinate of the current beat: x wraps per line, y sticks on the last line.
  always_comb begin
    if (sop_beat_s) begin
      px_s = {X_W{1'b0}};
      py_s = {Y_W{1'b0}};
    end else if (x_r == X_LAST) begin
      px_s = {X_W{1'b0}};
      py_s = (y_r == Y_LAST) ? y_r : y_r + Y_W'(1);
    end else begin
      px_s = x_r + X_W'(1);
      py_s = y_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // FSM next-state logic; REPORT accepts a new frame exactly like IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_REPORT: begin
        if (sop_beat_s) state_nxt_s = pix.in_eop ? ST_REPORT : ST_ACTIVE;
        else            state_nxt_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (pix.in_valid && pix.in_eop) state_nxt_s = ST_REPORT;
        else                            state_nxt_s = ST_ACTIVE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode; an sop beat restarts the frame from any state.
  always_comb begin
    frame_start_s = 1'b0;
    accum_s       = 1'b0;
    report_s      = 1'b0;
    case (state_r)
      ST_IDLE:   frame_start_s = sop_beat_s;
      ST_ACTIVE: begin
        frame_start_s = sop_beat_s;
        accum_s       = pix.in_valid & ~pix.in_sop;
      end
      ST_REPORT: begin
        frame_start_s = sop_beat_s;
        report_s      = 1'b1;
      end
      default: frame_start_s = 1'b0;
    endcase
  end

  // Config shadow and coordinate tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_h_lo_r  <= {H_W{1'b0}};
      sh_h_hi_r  <= {H_W{1'b0}};
      sh_s_min_r <= {SV_W{1'b0}};
      sh_v_min_r <= {SV_W{1'b0}};
      x_r        <= {X_W{1'b0}};
      y_r        <= {Y_W{1'b0}};
    end else begin
      if (sop_beat_s) begin
        sh_h_lo_r  <= cfg_h_lo;
        sh_h_hi_r  <= cfg_h_hi;
        sh_s_min_r <= cfg_s_min;
        sh_v_min_r <= cfg_v_min;
      end
      if (frame_start_s || accum_s) begin
        x_r <= px_s;
        y_r <= py_s;
      end
    end
  end

  // Bounding-box and count accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_x_min_r <= {X_W{1'b1}};
      acc_x_max_r <= {X_W{1'b0}};
      acc_y_min_r <= {Y_W{1'b1}};
      acc_y_max_r <= {Y_W{1'b0}};
      acc_count_r <= {CNT_W{1'b0}};
    end else if (frame_start_s) begin
      acc_x_min_r <= match_s ? px_s : {X_W{1'b1}};
      acc_x_max_r <= match_s ? px_s : {X_W{1'b0}};
      acc_y_min_r <= match_s ? py_s : {Y_W{1'b1}};
      acc_y_max_r <= match_s ? py_s : {Y_W{1'b0}};
      acc_count_r <= match_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (accum_s && match_s) begin
      if (px_s < acc_x_min_r) acc_x_min_r <= px_s;
      if (px_s > acc_x_max_r) acc_x_max_r <= px_s;
      if (py_s < acc_y_min_r) acc_y_min_r <= py_s;
      if (py_s > acc_y_max_r) acc_y_max_r <= py_s;
      if (acc_count_r != CNT_SAT) acc_count_r <= acc_count_r + CNT_W'(1);
    end
  end

  // Registered mask and frame report; an empty frame reports all-zero coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_valid <= 1'b0;
      mask       <= 1'b0;
      bbox_valid <= 1'b0;
      bbox_r     <= '{default: '0};
    end else begin
      mask_valid <= pix.in_valid;
      mask       <= pix.in_valid & match_s;
      bbox_valid <= report_s;
      if (report_s) begin
        bbox_r.count <= acc_count_r;
        bbox_r.found <= (acc_count_r >= CNT_MIN);
        if (acc_count_r == {CNT_W{1'b0}}) begin
          bbox_r.x_min <= {X_W{1'b0}};
          bbox_r.x_max <= {X_W{1'b0}};
          bbox_r.y_min <= {Y_W{1'b0}};
          bbox_r.y_max <= {Y_W{1'b0}};
        end else begin
          bbox_r.x_min <= acc_x_min_r;
          bbox_r.x_max <= acc_x_max_r;
          bbox_r.y_min <= acc_y_min_r;
          bbox_r.y_max <= acc_y_max_r;
        end
      end
    end
  end

  assign bbox_found = bbox_r.found;
  assign bbox_x_min = bbox_r.x_min;
  assign bbox_x_max = bbox_r.x_max;
  assign bbox_y_min = bbox_r.y_min;
  assign bbox_y_max = bbox_r.y_max;
  assign bbox_count = bbox_r.count;

endmodule
